// File: rtl/load_align_unit_pkg.sv
// Core-wide shared types: memory access operation encoding used by the load path.
package CorePack;

    typedef enum logic [2:0] {
        MEM_NO = 3'd0,
        MEM_B  = 3'd1,
        MEM_H  = 3'd2,
        MEM_W  = 3'd3,
        MEM_D  = 3'd4,
        MEM_UB = 3'd5,
        MEM_UH = 3'd6,
        MEM_UW = 3'd7
    } mem_op_enum;

endpackage

// File: rtl/load_align_unit_if.sv
// Request / memory / response bundle of the load-align unit; slave = the unit itself.
interface load_align_unit_if #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned ADDR_W = 64
);
    import CorePack::*;

    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    mem_op_enum        req_op;
    logic              mem_req_valid;
    logic              mem_req_ready;
    logic [ADDR_W-1:0] mem_req_addr;
    logic              mem_rsp_valid;
    logic [DATA_W-1:0] mem_rsp_data;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_err;

    modport slave (
        input  req_valid, req_addr, req_op, mem_req_ready, mem_rsp_valid, mem_rsp_data, rsp_ready,
        output req_ready, mem_req_valid, mem_req_addr, rsp_valid, rsp_data, rsp_err
    );

    modport master (
        output req_valid, req_addr, req_op, mem_req_ready, mem_rsp_valid, mem_rsp_data, rsp_ready,
        input  req_ready, mem_req_valid, mem_req_addr, rsp_valid, rsp_data, rsp_err
    );

endinterface

// File: rtl/load_align_unit.sv
// Load data path: one or two word reads, merge, shift, truncate and extend.
// Optional macro MISALIGN_TRAP_EN: word-crossing loads return rsp_err instead of two reads.
module load_align_unit #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned ADDR_W = 64
) (
    input  logic               clk,
    input  logic               rstn,
    load_align_unit_if.slave   bus
);
    import CorePack::*;

    localparam int unsigned BYTES = DATA_W / 8;
    localparam int unsigned OFF_W = $clog2(BYTES);
    localparam int unsigned SZ_W  = 4;

    typedef enum logic [2:0] {IDLE, REQ_LO, WAIT_LO, REQ_HI, WAIT_HI, DONE} state_t;

    function automatic logic [SZ_W-1:0] op_size(input mem_op_enum op);
        case (op)
            MEM_B, MEM_UB: op_size = 4'd1;
            MEM_H, MEM_UH: op_size = 4'd2;
            MEM_W, MEM_UW: op_size = 4'd4;
            MEM_D:         op_size = 4'd8;
            default:       op_size = 4'd0;
        endcase
    endfunction

    function automatic logic is_split(input logic [OFF_W-1:0] off, input mem_op_enum op);
        is_split = (SZ_W'(off) + op_size(op)) > SZ_W'(BYTES);
    endfunction

    // Shift the {hi,lo} pair down to the addressed byte, then truncate and extend.
    function automatic logic [DATA_W-1:0] align(input logic [2*DATA_W-1:0] pair,
                                                input logic [OFF_W-1:0]    off,
                                                input mem_op_enum          op);
        logic [2*DATA_W-1:0] sh;
        logic [DATA_W-1:0]   raw;
        sh  = pair >> {off, 3'b000};
        raw = sh[DATA_W-1:0];
        case (op)
            MEM_B:   align = DATA_W'($signed(raw[7:0]));
            MEM_H:   align = DATA_W'($signed(raw[15:0]));
            MEM_W:   align = DATA_W'($signed(raw[31:0]));
            MEM_UB:  align = DATA_W'(raw[7:0]);
            MEM_UH:  align = DATA_W'(raw[15:0]);
            MEM_UW:  align = DATA_W'(raw[31:0]);
            MEM_D:   align = raw;
            default: align = '0;
        endcase
    endfunction

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    mem_op_enum        op_q, op_d;
    logic [DATA_W-1:0] lo_q, lo_d;
    logic              req_ready_q, req_ready_d;
    logic              mem_req_valid_q, mem_req_valid_d;
    logic [ADDR_W-1:0] mem_req_addr_q, mem_req_addr_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic              rsp_err_q, rsp_err_d;

    logic [OFF_W-1:0]  off_q_c;
    logic [OFF_W-1:0]  off_in_c;
    logic              reject_c;

    always_comb begin
        state_d         = state_q;
        addr_d          = addr_q;
        op_d            = op_q;
        lo_d            = lo_q;
        req_ready_d     = req_ready_q;
        mem_req_valid_d = mem_req_valid_q;
        mem_req_addr_d  = mem_req_addr_q;
        rsp_valid_d     = rsp_valid_q;
        rsp_data_d      = rsp_data_q;
        rsp_err_d       = rsp_err_q;

        off_q_c  = addr_q[OFF_W-1:0];
        off_in_c = bus.req_addr[OFF_W-1:0];
`ifdef MISALIGN_TRAP_EN
        reject_c = (bus.req_op == MEM_NO) || (op_size(bus.req_op) > SZ_W'(BYTES)) ||
                   is_split(off_in_c, bus.req_op);
`else
        reject_c = (bus.req_op == MEM_NO) || (op_size(bus.req_op) > SZ_W'(BYTES));
`endif

        case (state_q)
            IDLE: begin
                if (bus.req_valid && req_ready_q) begin
                    addr_d      = bus.req_addr;
                    op_d        = bus.req_op;
                    lo_d        = '0;
                    req_ready_d = 1'b0;
                    if (reject_c) begin
                        // No memory traffic: MEM_NO is a clean zero, anything else is an error.
                        state_d     = DONE;
                        rsp_valid_d = 1'b1;
                        rsp_data_d  = '0;
                        rsp_err_d   = (bus.req_op != MEM_NO);
                    end else begin
                        state_d         = REQ_LO;
                        mem_req_valid_d = 1'b1;
                        mem_req_addr_d  = {bus.req_addr[ADDR_W-1:OFF_W], OFF_W'(0)};
                    end
                end
            end
            REQ_LO: begin
                if (bus.mem_req_ready) begin
                    state_d         = WAIT_LO;
                    mem_req_valid_d = 1'b0;
                end
            end
            WAIT_LO: begin
                if (bus.mem_rsp_valid) begin
                    lo_d = bus.mem_rsp_data;
`ifndef MISALIGN_TRAP_EN
                    if (is_split(off_q_c, op_q)) begin
                        state_d         = REQ_HI;
                        mem_req_valid_d = 1'b1;
                        mem_req_addr_d  = {addr_q[ADDR_W-1:OFF_W], OFF_W'(0)} + ADDR_W'(BYTES);
                    end else
`endif
                    begin
                        state_d     = DONE;
                        rsp_valid_d = 1'b1;
                        rsp_data_d  = align({DATA_W'(0), bus.mem_rsp_data}, off_q_c, op_q);
                        rsp_err_d   = 1'b0;
                    end
                end
            end
`ifndef MISALIGN_TRAP_EN
            REQ_HI: begin
                if (bus.mem_req_ready) begin
                    state_d         = WAIT_HI;
                    mem_req_valid_d = 1'b0;
                end
            end
            WAIT_HI: begin
                if (bus.mem_rsp_valid) begin
                    state_d     = DONE;
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = align({bus.mem_rsp_data, lo_q}, off_q_c, op_q);
                    rsp_err_d   = 1'b0;
                end
            end
`endif
            DONE: begin
                if (bus.rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                    rsp_data_d  = '0;
                    rsp_err_d   = 1'b0;
                    req_ready_d = 1'b1;
                end
            end
            default: begin
                state_d         = IDLE;
                req_ready_d     = 1'b1;
                mem_req_valid_d = 1'b0;
                rsp_valid_d     = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q         <= IDLE;
            addr_q          <= '0;
            op_q            <= MEM_NO;
            lo_q            <= '0;
            req_ready_q     <= 1'b1;
            mem_req_valid_q <= 1'b0;
            mem_req_addr_q  <= '0;
            rsp_valid_q     <= 1'b0;
            rsp_data_q      <= '0;
            rsp_err_q       <= 1'b0;
        end else begin
            state_q         <= state_d;
            addr_q          <= addr_d;
            op_q            <= op_d;
            lo_q            <= lo_d;
            req_ready_q     <= req_ready_d;
            mem_req_valid_q <= mem_req_valid_d;
            mem_req_addr_q  <= mem_req_addr_d;
            rsp_valid_q     <= rsp_valid_d;
            rsp_data_q      <= rsp_data_d;
            rsp_err_q       <= rsp_err_d;
        end
    end

    assign bus.req_ready     = req_ready_q;
    assign bus.mem_req_valid = mem_req_valid_q;
    assign bus.mem_req_addr  = mem_req_addr_q;
    assign bus.rsp_valid     = rsp_valid_q;
    assign bus.rsp_data      = rsp_data_q;
    assign bus.rsp_err       = rsp_err_q;

endmodule

// File: tb/tb_load_align_unit.sv
// Directed bench for load_align_unit: 64-bit instance with a word memory model, 32-bit instance for size legality.
module tb_load_align_unit;
    import CorePack::*;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    load_align_unit_if #(.DATA_W(64), .ADDR_W(64)) bus();
    load_align_unit    #(.DATA_W(64), .ADDR_W(64)) dut (.clk(clk), .rstn(rstn), .bus(bus));

    load_align_unit_if #(.DATA_W(32), .ADDR_W(32)) bus32();
    load_align_unit    #(.DATA_W(32), .ADDR_W(32)) dut32 (.clk(clk), .rstn(rstn), .bus(bus32));

    int          n_chk = 0;
    int          n_fail = 0;
    int          stall_left = 0;
    bit          hold_rsp = 1'b0;
    bit          pend = 1'b0;
    logic [63:0] pend_addr = '0;
    int          rd_cnt = 0;
    logic [63:0] rd_log [64];
    int          req32_cnt = 0;
    logic        prev_v = 1'b0;
    logic        prev_r = 1'b0;
    logic [63:0] prev_a = '0;

    function automatic logic [63:0] mem_word(input logic [63:0] a);
        case (a)
            64'h0000_0000_0000_1000: mem_word = 64'h8877_6655_4433_2211;
            64'h0000_0000_0000_1008: mem_word = 64'hFFEE_DDCC_BBAA_9988;
            64'hFFFF_FFFF_FFFF_FFF8: mem_word = 64'h0123_4567_89AB_CDEF;
            64'h0000_0000_0000_0000: mem_word = 64'h0000_0000_0000_00A5;
            default:                 mem_word = 64'hA5A5_A5A5_A5A5_A5A5;
        endcase
    endfunction

    // Word memory: optional request stall, response one cycle after acceptance, optional hold.
    always @(negedge clk) begin
        bus.mem_rsp_valid = 1'b0;
        if (pend && !hold_rsp) begin
            bus.mem_rsp_valid = 1'b1;
            bus.mem_rsp_data  = mem_word(pend_addr);
            pend = 1'b0;
        end
        if (bus.mem_req_valid === 1'b1 && stall_left > 0) begin
            bus.mem_req_ready = 1'b0;
            stall_left--;
        end else begin
            bus.mem_req_ready = 1'b1;
        end
        if (bus.mem_req_valid === 1'b1 && bus.mem_req_ready === 1'b1) begin
            pend      = 1'b1;
            pend_addr = bus.mem_req_addr;
            if (rd_cnt < 64) rd_log[rd_cnt] = bus.mem_req_addr;
            rd_cnt++;
        end
    end

    always @(negedge clk) begin
        if (bus32.mem_req_valid === 1'b1) req32_cnt++;
    end

    // A stalled memory request must keep its address until accepted.
    always @(negedge clk) begin
        #2;
        if (rstn && prev_v && !prev_r) begin
            n_chk++;
            if (bus.mem_req_valid !== 1'b1 || bus.mem_req_addr !== prev_a) begin
                n_fail++;
                $display("FAIL mem_req_hold: valid=%b addr=%h required valid=1 addr=%h",
                         bus.mem_req_valid, bus.mem_req_addr, prev_a);
            end
        end
        prev_v = bus.mem_req_valid;
        prev_r = bus.mem_req_ready;
        prev_a = bus.mem_req_addr;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Issue one load; lat counts cycles from the accept cycle to the first rsp_valid cycle.
    task automatic do_load(input logic [63:0] a, input mem_op_enum op, input int hold,
                           output logic [63:0] d, output logic e, output int lat,
                           output int nrd, output int first);
        first = rd_cnt;
        bus.req_addr  = a;
        bus.req_op    = op;
        bus.req_valid = 1'b1;
        tick();
        bus.req_valid = 1'b0;
        lat = 1;
        while (bus.rsp_valid !== 1'b1 && lat < 40) begin
            tick();
            lat++;
        end
        d = bus.rsp_data;
        e = bus.rsp_err;
        // Offer a competing request while the result is stalled; it must not be taken.
        if (hold > 0) begin
            bus.req_addr  = 64'h1000;
            bus.req_op    = MEM_D;
            bus.req_valid = 1'b1;
        end
        for (int i = 0; i < hold; i++) begin
            tick();
            n_chk++;
            if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== d || bus.rsp_err !== e ||
                bus.req_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL done_hold[%0d]: valid=%b data=%h err=%b req_ready=%b required 1 %h %b 0",
                         i, bus.rsp_valid, bus.rsp_data, bus.rsp_err, bus.req_ready, d, e);
            end
        end
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        nrd = rd_cnt - first;
    endtask

    task automatic test_reset();
        n_chk++;
        if (bus.req_ready !== 1'b1 || bus.mem_req_valid !== 1'b0 || bus.mem_req_addr !== 64'h0 ||
            bus.rsp_valid !== 1'b0 || bus.rsp_data !== 64'h0 || bus.rsp_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: rr=%b mv=%b ma=%h rv=%b rd=%h re=%b required 1 0 0 0 0 0",
                     bus.req_ready, bus.mem_req_valid, bus.mem_req_addr, bus.rsp_valid,
                     bus.rsp_data, bus.rsp_err);
        end
    endtask

    task automatic test_aligned();
        logic [63:0] va [3] = '{64'h1007, 64'h1002, 64'h1008};
        mem_op_enum  vo [3] = '{MEM_B, MEM_UH, MEM_UW};
        logic [63:0] vd [3] = '{64'hFFFF_FFFF_FFFF_FF88, 64'h0000_0000_0000_4433, 64'h0000_0000_BBAA_9988};
        logic [63:0] vr [3] = '{64'h1000, 64'h1000, 64'h1008};
        logic [63:0] d;
        logic        e;
        int          lat, nrd, first;
        for (int i = 0; i < 3; i++) begin
            do_load(va[i], vo[i], 0, d, e, lat, nrd, first);
            n_chk++;
            if (d !== vd[i] || e !== 1'b0) begin
                n_fail++;
                $display("FAIL aligned_data[%0d]: got %h err=%b required %h err=0", i, d, e, vd[i]);
            end
            n_chk++;
            if (lat !== 3) begin
                n_fail++;
                $display("FAIL aligned_latency[%0d]: got %0d required 3", i, lat);
            end
            n_chk++;
            if (nrd !== 1 || rd_log[first] !== vr[i]) begin
                n_fail++;
                $display("FAIL aligned_reads[%0d]: got %0d reads first=%h required 1 read at %h",
                         i, nrd, rd_log[first], vr[i]);
            end
        end
    endtask

    task automatic test_split();
        logic [63:0] va  [3] = '{64'h1006, 64'h1004, 64'hFFFF_FFFF_FFFF_FFFF};
        mem_op_enum  vo  [3] = '{MEM_W, MEM_D, MEM_H};
        logic [63:0] vd  [3] = '{64'hFFFF_FFFF_9988_8877, 64'hBBAA_9988_8877_6655, 64'hFFFF_FFFF_FFFF_A501};
        logic [63:0] vlo [3] = '{64'h1000, 64'h1000, 64'hFFFF_FFFF_FFFF_FFF8};
        logic [63:0] vhi [3] = '{64'h1008, 64'h1008, 64'h0};
        logic [63:0] d;
        logic        e;
        int          lat, nrd, first;
        for (int i = 0; i < 3; i++) begin
            do_load(va[i], vo[i], 0, d, e, lat, nrd, first);
`ifdef MISALIGN_TRAP_EN
            n_chk++;
            if (d !== 64'h0 || e !== 1'b1 || lat !== 1 || nrd !== 0) begin
                n_fail++;
                $display("FAIL split_trap[%0d]: data=%h err=%b lat=%0d reads=%0d required 0 1 1 0",
                         i, d, e, lat, nrd);
            end
`else
            n_chk++;
            if (d !== vd[i] || e !== 1'b0) begin
                n_fail++;
                $display("FAIL split_data[%0d]: got %h err=%b required %h err=0", i, d, e, vd[i]);
            end
            n_chk++;
            if (lat !== 5) begin
                n_fail++;
                $display("FAIL split_latency[%0d]: got %0d required 5", i, lat);
            end
            n_chk++;
            if (nrd !== 2 || rd_log[first] !== vlo[i] || rd_log[first+1] !== vhi[i]) begin
                n_fail++;
                $display("FAIL split_reads[%0d]: got %0d reads %h %h required 2 reads %h %h",
                         i, nrd, rd_log[first], rd_log[first+1], vlo[i], vhi[i]);
            end
`endif
        end
    endtask

    task automatic test_backpressure();
        logic [63:0] d;
        logic        e;
        int          lat, nrd, first, rd_after;
        stall_left = 2;
        do_load(64'h1007, MEM_B, 3, d, e, lat, nrd, first);
        n_chk++;
        if (d !== 64'hFFFF_FFFF_FFFF_FF88 || e !== 1'b0 || lat !== 5 || nrd !== 1 ||
            rd_log[first] !== 64'h1000) begin
            n_fail++;
            $display("FAIL stall_load: data=%h err=%b lat=%0d reads=%0d addr=%h required ffffffffffffff88 0 5 1 1000",
                     d, e, lat, nrd, rd_log[first]);
        end
        rd_after = rd_cnt;
        repeat (3) tick();
        n_chk++;
        if (rd_cnt !== rd_after || bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL no_reaccept: reads=%0d req_ready=%b rsp_valid=%b required %0d 1 0",
                     rd_cnt, bus.req_ready, bus.rsp_valid, rd_after);
        end
    endtask

    task automatic test_mem_no();
        logic [63:0] d;
        logic        e;
        int          lat, nrd, first;
        do_load(64'h1000, MEM_NO, 0, d, e, lat, nrd, first);
        n_chk++;
        if (d !== 64'h0 || e !== 1'b0 || lat !== 1 || nrd !== 0) begin
            n_fail++;
            $display("FAIL mem_no: data=%h err=%b lat=%0d reads=%0d required 0 0 1 0", d, e, lat, nrd);
        end
    endtask

    task automatic test_illegal_size();
        bus32.req_addr  = 32'h1000;
        bus32.req_op    = MEM_D;
        bus32.req_valid = 1'b1;
        tick();
        bus32.req_valid = 1'b0;
        n_chk++;
        if (bus32.rsp_valid !== 1'b1 || bus32.rsp_data !== 32'h0 || bus32.rsp_err !== 1'b1) begin
            n_fail++;
            $display("FAIL illegal_d32: valid=%b data=%h err=%b required 1 0 1",
                     bus32.rsp_valid, bus32.rsp_data, bus32.rsp_err);
        end
        bus32.rsp_ready = 1'b1;
        tick();
        bus32.rsp_ready = 1'b0;
        tick();
        n_chk++;
        if (req32_cnt !== 0 || bus32.req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL illegal_d32_noread: mem_req cycles=%0d req_ready=%b required 0 1",
                     req32_cnt, bus32.req_ready);
        end
    endtask

    task automatic test_reset_mid_op();
        logic [63:0] target, d;
        logic        e;
        int          n, lat, nrd, first;
`ifdef MISALIGN_TRAP_EN
        target = 64'h1000;
        bus.req_addr = 64'h1000;
        bus.req_op   = MEM_D;
`else
        target = 64'h1008;
        bus.req_addr = 64'h1006;
        bus.req_op   = MEM_W;
`endif
        bus.req_valid = 1'b1;
        tick();
        bus.req_valid = 1'b0;
        n = 0;
        while (!(bus.mem_req_valid === 1'b1 && bus.mem_req_addr === target) && n < 20) begin
            tick();
            n++;
        end
        n_chk++;
        if (n >= 20) begin
            n_fail++;
            $display("FAIL reset_reach: mem_req_addr=%h never seen, required %h", bus.mem_req_addr, target);
        end
        hold_rsp = 1'b1;
        tick();
        rstn = 1'b0;
        #1;
        n_chk++;
        if (bus.req_ready !== 1'b1 || bus.mem_req_valid !== 1'b0 || bus.mem_req_addr !== 64'h0 ||
            bus.rsp_valid !== 1'b0 || bus.rsp_data !== 64'h0 || bus.rsp_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_op: rr=%b mv=%b ma=%h rv=%b rd=%h re=%b required 1 0 0 0 0 0",
                     bus.req_ready, bus.mem_req_valid, bus.mem_req_addr, bus.rsp_valid,
                     bus.rsp_data, bus.rsp_err);
        end
        tick();
        rstn = 1'b1;
        tick();
        hold_rsp = 1'b0;
        repeat (3) tick();
        n_chk++;
        if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1 || bus.mem_req_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL stray_rsp: rsp_valid=%b req_ready=%b mem_req_valid=%b required 0 1 0",
                     bus.rsp_valid, bus.req_ready, bus.mem_req_valid);
        end
        do_load(64'h1007, MEM_B, 0, d, e, lat, nrd, first);
        n_chk++;
        if (d !== 64'hFFFF_FFFF_FFFF_FF88 || e !== 1'b0 || lat !== 3 || nrd !== 1) begin
            n_fail++;
            $display("FAIL post_reset_lb: data=%h err=%b lat=%0d reads=%0d required ffffffffffffff88 0 3 1",
                     d, e, lat, nrd);
        end
    endtask

    initial begin
        bus.req_valid   = 1'b0;
        bus.req_addr    = '0;
        bus.req_op      = MEM_NO;
        bus.rsp_ready   = 1'b0;
        bus32.req_valid = 1'b0;
        bus32.req_addr  = '0;
        bus32.req_op    = MEM_NO;
        bus32.rsp_ready = 1'b0;
        bus32.mem_req_ready = 1'b1;
        bus32.mem_rsp_valid = 1'b0;
        bus32.mem_rsp_data  = '0;
        rstn = 1'b0;
        repeat (2) tick();
        test_reset();
        rstn = 1'b1;
        tick();
        test_reset();
        test_aligned();
        test_split();
        test_backpressure();
        test_mem_no();
        test_illegal_size();
        test_reset_mid_op();
        repeat (2) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
